// File: rtl/cr_xp10_decomp_ob_arb.sv
// Frame-atomic round-robin arbiter: merges N_ENG decompressor output streams
// onto one registered AXI4-stream port without interleaving frames.
module cr_xp10_decomp_ob_arb #(
    parameter int unsigned N_ENG       = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned USER_W      = 8,
    parameter int unsigned STRB_W      = 8,
    parameter int unsigned ID_W        = 1,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ENG-1:0]           eng_tvalid,
    input  logic [N_ENG-1:0]           eng_tlast,
    input  logic [N_ENG*ID_W-1:0]      eng_tid,
    input  logic [N_ENG*STRB_W-1:0]    eng_tstrb,
    input  logic [N_ENG*USER_W-1:0]    eng_tuser,
    input  logic [N_ENG*DATA_W-1:0]    eng_tdata,
    output logic [N_ENG-1:0]           eng_tready,
    output logic                       ob_tvalid,
    output logic                       ob_tlast,
    output logic [ID_W-1:0]            ob_tid,
    output logic [STRB_W-1:0]          ob_tstrb,
    output logic [USER_W-1:0]          ob_tuser,
    output logic [DATA_W-1:0]          ob_tdata,
    input  logic                       ob_tready,
    input  logic                       arb_en,
    output logic [N_ENG-1:0]           frame_done,
    output logic [$clog2(N_ENG)-1:0]   grant_id,
    output logic                       busy,
    output logic                       stall_err
);

    localparam int unsigned GID_W = $clog2(N_ENG);
    localparam int unsigned WD_W  = $clog2(STALL_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                ob_tvalid_q, ob_tvalid_d;
    logic                ob_tlast_q, ob_tlast_d;
    logic [ID_W-1:0]     ob_tid_q, ob_tid_d;
    logic [STRB_W-1:0]   ob_tstrb_q, ob_tstrb_d;
    logic [USER_W-1:0]   ob_tuser_q, ob_tuser_d;
    logic [DATA_W-1:0]   ob_tdata_q, ob_tdata_d;
    logic [N_ENG-1:0]    frame_done_q, frame_done_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                stall_err_q, stall_err_d;

    // Per-engine payload views unpacked for indexing by the granted engine
    logic [ID_W-1:0]     tid_a   [N_ENG];
    logic [STRB_W-1:0]   tstrb_a [N_ENG];
    logic [USER_W-1:0]   tuser_a [N_ENG];
    logic [DATA_W-1:0]   tdata_a [N_ENG];

    for (genvar i = 0; i < N_ENG; i++) begin : g_unpack
        assign tid_a[i]   = eng_tid[i*ID_W +: ID_W];
        assign tstrb_a[i] = eng_tstrb[i*STRB_W +: STRB_W];
        assign tuser_a[i] = eng_tuser[i*USER_W +: USER_W];
        assign tdata_a[i] = eng_tdata[i*DATA_W +: DATA_W];
    end

    logic                slice_ready;
    logic                accept;
    logic                g_tvalid;
    logic                g_tlast;
    logic [N_ENG-1:0]    grant_oh;
    logic                pick_found;
    logic [GID_W-1:0]    pick_idx;
    logic [GID_W:0]      cand;
    logic [GID_W-1:0]    rr_next;

    // Next-state, output-slice and watchdog logic
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        ob_tvalid_d  = ob_tvalid_q;
        ob_tlast_d   = ob_tlast_q;
        ob_tid_d     = ob_tid_q;
        ob_tstrb_d   = ob_tstrb_q;
        ob_tuser_d   = ob_tuser_q;
        ob_tdata_d   = ob_tdata_q;
        frame_done_d = '0;
        wd_cnt_d     = wd_cnt_q;
        stall_err_d  = stall_err_q;
        eng_tready   = '0;
        pick_found   = 1'b0;
        pick_idx     = '0;
        cand         = '0;

        slice_ready = !ob_tvalid_q || ob_tready;
        g_tvalid    = eng_tvalid[grant_q];
        g_tlast     = eng_tlast[grant_q];
        grant_oh    = N_ENG'(1) << grant_q;
        accept      = (state_q == ST_LOCK) && g_tvalid && slice_ready;
        rr_next     = (grant_q == GID_W'(N_ENG - 1)) ? '0 : grant_q + GID_W'(1);

        // First requester at or after the round-robin pointer
        for (int unsigned k = 0; k < N_ENG; k++) begin
            cand = {1'b0, rr_ptr_q} + (GID_W + 1)'(k);
            if (cand >= (GID_W + 1)'(N_ENG)) begin
                cand = cand - (GID_W + 1)'(N_ENG);
            end
            if (!pick_found && eng_tvalid[cand[GID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[GID_W-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_en && pick_found) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (slice_ready) begin
                    eng_tready = grant_oh;
                end
                if (accept && g_tlast) begin
                    frame_done_d = grant_oh;
                    rr_ptr_d     = rr_next;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output slice: refill whenever empty or draining
        if (slice_ready) begin
            ob_tvalid_d = accept;
        end
        if (accept) begin
            ob_tlast_d = g_tlast;
            ob_tid_d   = tid_a[grant_q];
            ob_tstrb_d = tstrb_a[grant_q];
            ob_tuser_d = tuser_a[grant_q];
            ob_tdata_d = tdata_a[grant_q];
        end

        // Watchdog counts only granted-engine starvation, not output backpressure
        if ((state_q != ST_LOCK) || accept) begin
            wd_cnt_d = '0;
        end else if (!g_tvalid && (wd_cnt_q != WD_W'(STALL_LIMIT))) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (wd_cnt_d == WD_W'(STALL_LIMIT)) begin
            stall_err_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            ob_tvalid_q  <= 1'b0;
            ob_tlast_q   <= 1'b0;
            ob_tid_q     <= '0;
            ob_tstrb_q   <= '0;
            ob_tuser_q   <= '0;
            ob_tdata_q   <= '0;
            frame_done_q <= '0;
            wd_cnt_q     <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            ob_tvalid_q  <= ob_tvalid_d;
            ob_tlast_q   <= ob_tlast_d;
            ob_tid_q     <= ob_tid_d;
            ob_tstrb_q   <= ob_tstrb_d;
            ob_tuser_q   <= ob_tuser_d;
            ob_tdata_q   <= ob_tdata_d;
            frame_done_q <= frame_done_d;
            wd_cnt_q     <= wd_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign ob_tvalid  = ob_tvalid_q;
    assign ob_tlast   = ob_tlast_q;
    assign ob_tid     = ob_tid_q;
    assign ob_tstrb   = ob_tstrb_q;
    assign ob_tuser   = ob_tuser_q;
    assign ob_tdata   = ob_tdata_q;
    assign frame_done = frame_done_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_cr_xp10_decomp_ob_arb.sv
// Directed bench for cr_xp10_decomp_ob_arb: per-engine beat queues feed the
// DUT, accepted output beats are logged and checked against hand-built values.
module tb_cr_xp10_decomp_ob_arb;

    localparam int unsigned N_ENG       = 4;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned USER_W      = 8;
    localparam int unsigned STRB_W      = 8;
    localparam int unsigned ID_W        = 1;
    localparam int unsigned STALL_LIMIT = 16;

    logic                     clk;
    logic                     rst;
    logic [N_ENG-1:0]         eng_tvalid;
    logic [N_ENG-1:0]         eng_tlast;
    logic [N_ENG*ID_W-1:0]    eng_tid;
    logic [N_ENG*STRB_W-1:0]  eng_tstrb;
    logic [N_ENG*USER_W-1:0]  eng_tuser;
    logic [N_ENG*DATA_W-1:0]  eng_tdata;
    logic [N_ENG-1:0]         eng_tready;
    logic                     ob_tvalid;
    logic                     ob_tlast;
    logic [ID_W-1:0]          ob_tid;
    logic [STRB_W-1:0]        ob_tstrb;
    logic [USER_W-1:0]        ob_tuser;
    logic [DATA_W-1:0]        ob_tdata;
    logic                     ob_tready;
    logic                     arb_en;
    logic [N_ENG-1:0]         frame_done;
    logic [1:0]               grant_id;
    logic                     busy;
    logic                     stall_err;

    cr_xp10_decomp_ob_arb #(
        .N_ENG(N_ENG), .DATA_W(DATA_W), .USER_W(USER_W), .STRB_W(STRB_W),
        .ID_W(ID_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .eng_tvalid(eng_tvalid), .eng_tlast(eng_tlast), .eng_tid(eng_tid),
        .eng_tstrb(eng_tstrb), .eng_tuser(eng_tuser), .eng_tdata(eng_tdata),
        .eng_tready(eng_tready),
        .ob_tvalid(ob_tvalid), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
        .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tdata(ob_tdata),
        .ob_tready(ob_tready), .arb_en(arb_en), .frame_done(frame_done),
        .grant_id(grant_id), .busy(busy), .stall_err(stall_err)
    );

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t src_q [N_ENG][$];
    beat_t out_q [$];
    int    out_cyc [$];
    int    cyc;
    int    n_vec;
    int    n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_src();
        for (int i = 0; i < int'(N_ENG); i++) begin
            if (src_q[i].size() > 0) begin
                eng_tvalid[i] = 1'b1;
                eng_tlast[i]  = src_q[i][0].last;
                eng_tdata[i*DATA_W +: DATA_W] = src_q[i][0].data;
            end else begin
                eng_tvalid[i] = 1'b0;
                eng_tlast[i]  = 1'b0;
                eng_tdata[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    // One clock: record handshakes just before the edge, then advance
    task automatic tick();
        beat_t b;
        drive_src();
        #1;
        for (int i = 0; i < int'(N_ENG); i++) begin
            if (eng_tvalid[i] && eng_tready[i]) void'(src_q[i].pop_front());
        end
        if (ob_tvalid && ob_tready) begin
            b = {ob_tlast, ob_tdata};
            out_q.push_back(b);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_src();
    endtask

    task automatic add_frame(input int e, input int n, input int base);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.data = DATA_W'(base + b);
            x.last = (b == n - 1);
            src_q[e].push_back(x);
        end
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < int'(N_ENG); i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < int'(N_ENG); i++) src_q[i].delete();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic drain(input int max, output int used);
        used = 0;
        while ((src_pending() || ob_tvalid) && used < max) begin
            tick();
            used++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        arb_en    = 1'b1;
        ob_tready = 1'b1;
        clear_all();
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (ob_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_ob_tvalid: got %b want 0", ob_tvalid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_vec++; if (stall_err !== 1'b0) begin n_err++; $display("FAIL reset_stall_err: got %b want 0", stall_err); end
        n_vec++; if (frame_done !== 4'b0000) begin n_err++; $display("FAIL reset_frame_done: got %b want 0000", frame_done); end
        n_vec++; if (eng_tready !== 4'b0000) begin n_err++; $display("FAIL reset_eng_tready: got %b want 0000", eng_tready); end
    endtask

    task automatic test_single();
        clear_all();
        add_frame(2, 3, 'hA0);
        tick();
        n_vec++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant: busy=%b grant=%0d want busy=1 grant=2", busy, grant_id); end
        n_vec++; if (ob_tvalid !== 1'b0) begin n_err++; $display("FAIL single_no_beat_in_decision: got %b want 0", ob_tvalid); end
        n_vec++; if (eng_tready !== 4'b0100) begin n_err++; $display("FAIL single_tready: got %b want 0100", eng_tready); end
        tick();
        n_vec++; if (ob_tvalid !== 1'b1 || ob_tdata !== 64'hA0 || ob_tlast !== 1'b0) begin n_err++; $display("FAIL single_beat0: v=%b d=%h l=%b want v=1 d=a0 l=0", ob_tvalid, ob_tdata, ob_tlast); end
        n_vec++; if (ob_tuser !== 8'h12 || ob_tstrb !== 8'h33 || ob_tid !== 1'b1) begin n_err++; $display("FAIL single_sideband: user=%h strb=%h id=%b want 12 33 1", ob_tuser, ob_tstrb, ob_tid); end
        tick();
        n_vec++; if (ob_tvalid !== 1'b1 || ob_tdata !== 64'hA1 || frame_done !== 4'b0000) begin n_err++; $display("FAIL single_beat1: v=%b d=%h fd=%b want v=1 d=a1 fd=0000", ob_tvalid, ob_tdata, frame_done); end
        tick();
        n_vec++; if (ob_tdata !== 64'hA2 || ob_tlast !== 1'b1) begin n_err++; $display("FAIL single_beat2: d=%h l=%b want a2 1", ob_tdata, ob_tlast); end
        n_vec++; if (frame_done !== 4'b0100 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: fd=%b busy=%b want 0100 0", frame_done, busy); end
        tick();
        n_vec++; if (ob_tvalid !== 1'b0 || frame_done !== 4'b0000) begin n_err++; $display("FAIL single_after: v=%b fd=%b want 0 0000", ob_tvalid, frame_done); end
    endtask

    task automatic test_arb_en();
        int e_data;
        clear_all();
        add_frame(3, 5, 'hD0);
        add_frame(0, 1, 'hE0);
        tick();
        n_vec++; if (grant_id !== 2'd3 || busy !== 1'b1) begin n_err++; $display("FAIL arb_rr_after_eng2: grant=%0d busy=%b want 3 1", grant_id, busy); end
        tick();
        tick();
        arb_en = 1'b0;
        repeat (7) tick();
        n_vec++; if (busy !== 1'b0 || ob_tvalid !== 1'b0 || grant_id !== 2'd3) begin n_err++; $display("FAIL arb_suppressed: busy=%b v=%b grant=%0d want 0 0 3", busy, ob_tvalid, grant_id); end
        n_vec++; if (out_q.size() !== 5) begin n_err++; $display("FAIL arb_frame_beats: got %0d want 5", out_q.size()); end
        for (int j = 0; j < out_q.size() && j < 5; j++) begin
            e_data = 'hD0 + j;
            n_vec++;
            if (out_q[j].data !== DATA_W'(e_data) || out_q[j].last !== (j == 4)) begin
                n_err++; $display("FAIL arb_beat%0d: d=%h l=%b want d=%h l=%b", j, out_q[j].data, out_q[j].last, e_data, (j == 4));
            end
        end
        arb_en = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("FAIL arb_resume: busy=%b grant=%0d want 1 0", busy, grant_id); end
        tick();
        n_vec++; if (ob_tdata !== 64'hE0 || ob_tlast !== 1'b1 || frame_done !== 4'b0001) begin n_err++; $display("FAIL arb_one_beat: d=%h l=%b fd=%b want e0 1 0001", ob_tdata, ob_tlast, frame_done); end
        tick();
    endtask

    task automatic test_round_robin();
        int used, fi, e, f, b, exp_d, exp_gap;
        do_reset();
        for (int ff = 0; ff < 2; ff++)
            for (int ee = 0; ee < 4; ee++) add_frame(ee, 2, (ee << 8) | (ff << 4));
        drain(80, used);
        n_vec++; if (used >= 80) begin n_err++; $display("FAIL rr_timeout: used %0d cycles, limit 80", used); end
        n_vec++; if (out_q.size() !== 16) begin n_err++; $display("FAIL rr_beat_count: got %0d want 16", out_q.size()); end
        for (int j = 0; j < out_q.size() && j < 16; j++) begin
            fi = j / 2; f = fi / 4; e = fi % 4; b = j % 2;
            exp_d = (e << 8) | (f << 4) | b;
            n_vec++;
            if (out_q[j].data !== DATA_W'(exp_d) || out_q[j].last !== (b == 1)) begin
                n_err++; $display("FAIL rr_beat%0d: d=%h l=%b want d=%h l=%b", j, out_q[j].data, out_q[j].last, exp_d, (b == 1));
            end
            if (j > 0) begin
                exp_gap = (b == 1) ? 1 : 2;
                n_vec++;
                if (out_cyc[j] - out_cyc[j-1] !== exp_gap) begin
                    n_err++; $display("FAIL rr_gap%0d: got %0d want %0d", j, out_cyc[j] - out_cyc[j-1], exp_gap);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]        pat;
        logic              held, hl;
        logic [DATA_W-1:0] hd;
        int                k, exp_d;
        clear_all();
        pat = 4'b1001;
        add_frame(1, 4, 'hB0);
        k = 0;
        while ((src_pending() || ob_tvalid) && k < 40) begin
            ob_tready = pat[k % 4];
            #1;
            n_vec++; if ((eng_tready & 4'b1101) !== 4'b0000) begin n_err++; $display("FAIL bp_other_tready: got %b want x0xx clear", eng_tready); end
            if (ob_tvalid && !ob_tready) begin
                n_vec++; if (eng_tready[1] !== 1'b0) begin n_err++; $display("FAIL bp_tready_full: got %b want 0", eng_tready[1]); end
            end
            held = ob_tvalid && !ob_tready;
            hd   = ob_tdata;
            hl   = ob_tlast;
            tick();
            if (held) begin
                n_vec++;
                if (ob_tvalid !== 1'b1 || ob_tdata !== hd || ob_tlast !== hl) begin
                    n_err++; $display("FAIL bp_hold: v=%b d=%h l=%b want v=1 d=%h l=%b", ob_tvalid, ob_tdata, ob_tlast, hd, hl);
                end
            end
            k++;
        end
        ob_tready = 1'b1;
        n_vec++; if (k >= 40) begin n_err++; $display("FAIL bp_timeout: used %0d cycles, limit 40", k); end
        n_vec++; if (out_q.size() !== 4) begin n_err++; $display("FAIL bp_beat_count: got %0d want 4", out_q.size()); end
        for (int j = 0; j < out_q.size() && j < 4; j++) begin
            exp_d = 'hB0 + j;
            n_vec++;
            if (out_q[j].data !== DATA_W'(exp_d) || out_q[j].last !== (j == 3)) begin
                n_err++; $display("FAIL bp_beat%0d: d=%h l=%b want d=%h l=%b", j, out_q[j].data, out_q[j].last, exp_d, (j == 3));
            end
        end
    endtask

    task automatic test_watchdog();
        beat_t x;
        int    used;
        do_reset();
        x.data = 'hC0; x.last = 1'b0;
        src_q[0].push_back(x);
        tick();
        tick();
        repeat (15) tick();
        n_vec++; if (stall_err !== 1'b0) begin n_err++; $display("FAIL wd_early: got %b want 0 after 15 idle cycles", stall_err); end
        tick();
        n_vec++; if (stall_err !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL wd_trip: stall=%b busy=%b want 1 1", stall_err, busy); end
        x.data = 'hC1; x.last = 1'b1;
        src_q[0].push_back(x);
        drain(20, used);
        n_vec++; if (used >= 20) begin n_err++; $display("FAIL wd_timeout: used %0d cycles, limit 20", used); end
        n_vec++; if (stall_err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL wd_sticky: stall=%b busy=%b want 1 0", stall_err, busy); end
        n_vec++; if (out_q.size() !== 2) begin n_err++; $display("FAIL wd_beat_count: got %0d want 2", out_q.size()); end
        else begin
            n_vec++; if (out_q[1].data !== 64'hC1 || out_q[1].last !== 1'b1) begin n_err++; $display("FAIL wd_last_beat: d=%h l=%b want c1 1", out_q[1].data, out_q[1].last); end
        end
    endtask

    task automatic test_rst_mid_frame();
        int used;
        clear_all();
        add_frame(2, 4, 'hF0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (ob_tvalid !== 1'b0 || ob_tlast !== 1'b0 || ob_tdata !== 64'h0) begin n_err++; $display("FAIL rst_slice: v=%b l=%b d=%h want 0 0 0", ob_tvalid, ob_tlast, ob_tdata); end
        n_vec++; if (busy !== 1'b0 || grant_id !== 2'd0 || frame_done !== 4'b0000) begin n_err++; $display("FAIL rst_ctrl: busy=%b grant=%0d fd=%b want 0 0 0000", busy, grant_id, frame_done); end
        n_vec++; if (eng_tready !== 4'b0000 || stall_err !== 1'b0) begin n_err++; $display("FAIL rst_ready_stall: tready=%b stall=%b want 0000 0", eng_tready, stall_err); end
        clear_all();
        drive_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_frame(3, 1, 'h33);
        add_frame(0, 1, 'h01);
        tick();
        n_vec++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL rst_first_grant: grant=%0d busy=%b want 0 1", grant_id, busy); end
        drain(20, used);
        n_vec++; if (used >= 20) begin n_err++; $display("FAIL rst_timeout: used %0d cycles, limit 20", used); end
        n_vec++; if (out_q.size() !== 2) begin n_err++; $display("FAIL rst_beat_count: got %0d want 2", out_q.size()); end
        else begin
            n_vec++; if (out_q[0].data !== 64'h01 || out_q[1].data !== 64'h33) begin n_err++; $display("FAIL rst_order: got %h,%h want 01,33", out_q[0].data, out_q[1].data); end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        rst        = 1'b1;
        arb_en     = 1'b1;
        ob_tready  = 1'b1;
        eng_tvalid = '0;
        eng_tlast  = '0;
        eng_tdata  = '0;
        eng_tid    = 4'b1100;
        eng_tuser  = {8'h13, 8'h12, 8'h11, 8'h10};
        eng_tstrb  = {8'h0F, 8'h33, 8'hFF, 8'h01};

        test_reset();
        test_single();
        test_arb_en();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_rst_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
